// File: rtl/lcd_pkg.sv
// Shared state encoding, PIO bit map and register constants for the LCD PIO sequencer.
package lcd_pkg;

   typedef enum logic [4:0] {
      StIdle,
      StPDir, StPSet, StPWsu, StPEhi, StPWpw, StPRd, StPSmp, StPElo, StPWhd,
      StWDir, StWSet, StWWsu, StWEhi, StWWpw, StWElo, StWWhd
   } lcd_state_e;

   localparam int unsigned LCD_BUSY = 7;
   localparam int unsigned LCD_RS   = 8;
   localparam int unsigned LCD_RW   = 9;
   localparam int unsigned LCD_E    = 10;
   localparam int unsigned LCD_BL   = 11;

   localparam logic [15:0] DIR_WRITE = 16'h0FFF;
   localparam logic [15:0] DIR_POLL  = 16'h0F00;

   localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
   localparam logic [1:0] PIO_ADDR_DIR  = 2'd1;

   // Packs one OUT-register word; bits 31:12 are always zero.
   function automatic logic [31:0] lcd_out_word(input logic [7:0] data, input logic rs,
                                                input logic rw, input logic e, input logic bl);
      logic [31:0] w;
      w         = '0;
      w[7:0]    = data;
      w[LCD_RS] = rs;
      w[LCD_RW] = rw;
      w[LCD_E]  = e;
      w[LCD_BL] = bl;
      return w;
   endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter; done is high while the count sits at zero.
module lcd_delay_counter #(
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          load,
   input  logic [CW-1:0] load_value,
   output logic          done
);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_value;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_pio_sequencer.sv
// Avalon-MM master that turns byte commands into timed E-strobe writes on the LCD PIO,
// optionally polling the busy flag first.
module lcd_pio_sequencer
   import lcd_pkg::*;
#(
   parameter int unsigned T_SETUP    = 3,
   parameter int unsigned T_PULSE    = 25,
   parameter int unsigned T_HOLD     = 3,
   parameter int unsigned POLL_LIMIT = 1024,
   parameter int unsigned CW         = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_rs,
   input  logic [7:0]  cmd_data,
   input  logic        poll_en,
   input  logic        bl_on,
   output logic        timeout_err,
   input  logic        err_clr,
   output logic [1:0]  pio_address,
   output logic        pio_chipselect,
   output logic        pio_write_n,
   output logic [31:0] pio_writedata,
   input  logic [31:0] pio_readdata
);

   localparam logic [CW-1:0] SetupLoad = CW'(T_SETUP - 1);
   localparam logic [CW-1:0] PulseLoad = CW'(T_PULSE - 1);
   localparam logic [CW-1:0] HoldLoad  = CW'(T_HOLD - 1);
   localparam logic [CW-1:0] PollMax   = CW'(POLL_LIMIT);

   lcd_state_e    state_q, state_d;
   logic          rs_q;
   logic [7:0]    data_q;
   logic          busy_q;
   logic [CW-1:0] poll_cnt_q;
   logic          timeout_err_q;

   logic          accept;
   logic          timeout_set;
   logic          dly_load;
   logic [CW-1:0] dly_value;
   logic          dly_done;
   logic          bus_wr;
   logic          bus_rd;
   logic [1:0]    bus_addr;
   logic [31:0]   bus_word;
   logic          unused_rd;

   assign accept    = (state_q == StIdle) && cmd_valid;
   assign unused_rd = ^{pio_readdata[31:8], pio_readdata[6:0]};

   lcd_delay_counter #(
      .CW(CW)
   ) u_delay (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (dly_load),
      .load_value(dly_value),
      .done      (dly_done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         rs_q          <= 1'b0;
         data_q        <= '0;
         busy_q        <= 1'b0;
         poll_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            rs_q       <= cmd_rs;
            data_q     <= cmd_data;
            poll_cnt_q <= '0;
         end
         // readdata is registered in the PIO, so it is valid one cycle after the read
         if (state_q == StPSmp) begin
            busy_q     <= pio_readdata[LCD_BUSY];
            poll_cnt_q <= poll_cnt_q + CW'(1);
         end
         if (timeout_set) begin
            timeout_err_q <= 1'b1;
         end else if (err_clr) begin
            timeout_err_q <= 1'b0;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      dly_load    = 1'b0;
      dly_value   = '0;
      bus_wr      = 1'b0;
      bus_rd      = 1'b0;
      bus_addr    = PIO_ADDR_DATA;
      bus_word    = '0;
      timeout_set = 1'b0;
      unique case (state_q)
         StIdle: if (cmd_valid) state_d = poll_en ? StPDir : StWDir;
         StPDir: begin
            bus_wr   = 1'b1;
            bus_addr = PIO_ADDR_DIR;
            bus_word = {16'h0000, DIR_POLL};
            state_d  = StPSet;
         end
         StPSet: begin
            bus_wr    = 1'b1;
            bus_word  = lcd_out_word(8'h00, 1'b0, 1'b1, 1'b0, bl_on);
            dly_load  = 1'b1;
            dly_value = SetupLoad;
            state_d   = StPWsu;
         end
         StPWsu: if (dly_done) state_d = StPEhi;
         StPEhi: begin
            bus_wr    = 1'b1;
            bus_word  = lcd_out_word(8'h00, 1'b0, 1'b1, 1'b1, bl_on);
            dly_load  = 1'b1;
            dly_value = PulseLoad;
            state_d   = StPWpw;
         end
         StPWpw: if (dly_done) state_d = StPRd;
         StPRd: begin
            bus_rd  = 1'b1;
            state_d = StPSmp;
         end
         StPSmp: state_d = StPElo;
         StPElo: begin
            bus_wr    = 1'b1;
            bus_word  = lcd_out_word(8'h00, 1'b0, 1'b1, 1'b0, bl_on);
            dly_load  = 1'b1;
            dly_value = HoldLoad;
            state_d   = StPWhd;
         end
         StPWhd: begin
            if (dly_done) begin
               if (!busy_q) begin
                  state_d = StWDir;
               end else if (poll_cnt_q >= PollMax) begin
                  timeout_set = 1'b1;
                  state_d     = StIdle;
               end else begin
                  state_d = StPSet;
               end
            end
         end
         StWDir: begin
            bus_wr   = 1'b1;
            bus_addr = PIO_ADDR_DIR;
            bus_word = {16'h0000, DIR_WRITE};
            state_d  = StWSet;
         end
         StWSet: begin
            bus_wr    = 1'b1;
            bus_word  = lcd_out_word(data_q, rs_q, 1'b0, 1'b0, bl_on);
            dly_load  = 1'b1;
            dly_value = SetupLoad;
            state_d   = StWWsu;
         end
         StWWsu: if (dly_done) state_d = StWEhi;
         StWEhi: begin
            bus_wr    = 1'b1;
            bus_word  = lcd_out_word(data_q, rs_q, 1'b0, 1'b1, bl_on);
            dly_load  = 1'b1;
            dly_value = PulseLoad;
            state_d   = StWWpw;
         end
         StWWpw: if (dly_done) state_d = StWElo;
         StWElo: begin
            bus_wr    = 1'b1;
            bus_word  = lcd_out_word(data_q, rs_q, 1'b0, 1'b0, bl_on);
            dly_load  = 1'b1;
            dly_value = HoldLoad;
            state_d   = StWWhd;
         end
         StWWhd: if (dly_done) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign cmd_ready      = (state_q == StIdle);
   assign timeout_err    = timeout_err_q;
   assign pio_chipselect = bus_wr | bus_rd;
   assign pio_write_n    = ~bus_wr;
   assign pio_address    = bus_addr;
   assign pio_writedata  = bus_word;

endmodule

// File: tb/tb_lcd_pio_sequencer.sv
// Self-checking bench: PIO/LCD busy model, bus monitor and a transaction-level reference model.
module tb_lcd_pio_sequencer;

   localparam int PollLimit = 4;

   typedef struct packed {
      logic [1:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_rs = 1'b0;
   logic [7:0]  cmd_data = 8'h00;
   logic        poll_en = 1'b0;
   logic        bl_on = 1'b0;
   logic        timeout_err;
   logic        err_clr = 1'b0;
   logic [1:0]  pio_address;
   logic        pio_chipselect;
   logic        pio_write_n;
   logic [31:0] pio_writedata;
   logic [31:0] pio_readdata;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rd_total = 0;
   int rd_base = 0;
   int busy_target = 0;
   int wb, ab, acc_cyc, rdy_cyc;
   wr_t wr_log[$];
   int  wr_cyc[$];
   int  acc_q[$];
   wr_t exp_q[$];

   always #5 clk = ~clk;

   lcd_pio_sequencer #(
      .T_SETUP   (3),
      .T_PULSE   (25),
      .T_HOLD    (3),
      .POLL_LIMIT(PollLimit),
      .CW        (16)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_rs        (cmd_rs),
      .cmd_data      (cmd_data),
      .poll_en       (poll_en),
      .bl_on         (bl_on),
      .timeout_err   (timeout_err),
      .err_clr       (err_clr),
      .pio_address   (pio_address),
      .pio_chipselect(pio_chipselect),
      .pio_write_n   (pio_write_n),
      .pio_writedata (pio_writedata),
      .pio_readdata  (pio_readdata)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset_n) begin
         if (pio_chipselect && !pio_write_n) begin
            wr_log.push_back(mk(pio_address, pio_writedata));
            wr_cyc.push_back(cyc);
         end
         if (pio_chipselect && pio_write_n) rd_total++;
         if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
      end
   end

   // PIO read port: the LCD reports busy for the first busy_target reads of a command.
   // Outside a read response the bus shows busy, so off-by-one sampling is visible.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) pio_readdata <= '0;
      else if (pio_chipselect && pio_write_n && pio_address == 2'd0)
         pio_readdata <= {20'h0, 4'($urandom), ((rd_total - rd_base) <= busy_target),
                          7'($urandom)};
      else pio_readdata <= 32'h0000_0080;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1);
   end

   function automatic wr_t mk(input logic [1:0] a, input logic [31:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      return w;
   endfunction

   // Appends the expected bus writes of one command; returns 1 if it should time out.
   function automatic bit model_cmd(input logic rs, input logic [7:0] d, input logic poll,
                                    input logic bl, input int busy);
      logic [31:0] blw, wd;
      int npoll;
      blw = bl ? 32'h800 : 32'h0;
      if (poll) begin
         exp_q.push_back(mk(2'd1, 32'h0F00));
         npoll = (busy >= PollLimit) ? PollLimit : busy + 1;
         for (int i = 0; i < npoll; i++) begin
            exp_q.push_back(mk(2'd0, blw + 32'h200));
            exp_q.push_back(mk(2'd0, blw + 32'h600));
            exp_q.push_back(mk(2'd0, blw + 32'h200));
         end
         if (busy >= PollLimit) return 1'b1;
      end
      wd = blw + (rs ? 32'h100 : 32'h0) + {24'h0, d};
      exp_q.push_back(mk(2'd1, 32'h0FFF));
      exp_q.push_back(mk(2'd0, wd));
      exp_q.push_back(mk(2'd0, wd + 32'h400));
      exp_q.push_back(mk(2'd0, wd));
      return 1'b0;
   endfunction

   task automatic issue(input logic rs, input logic [7:0] d, input logic poll, input logic bl,
                        input int busy, input logic clr);
      int n = 0;
      wb = wr_log.size();
      ab = acc_q.size();
      rd_base = rd_total;
      busy_target = busy;
      cmd_rs = rs; cmd_data = d; poll_en = poll; bl_on = bl; err_clr = clr;
      cmd_valid = 1'b1;
      while (acc_q.size() == ab && n < 20) begin @(posedge clk); #1; n++; end
      cmd_valid = 1'b0;
      checks++;
      if (acc_q.size() != ab + 1) begin
         errors++;
         $display("FAIL accept got %0d want 1", acc_q.size() - ab);
      end
      acc_cyc = (acc_q.size() > ab) ? acc_q[ab] : cyc;
      n = 0;
      while (!cmd_ready && n < 2000) begin @(posedge clk); #1; n++; end
      err_clr = 1'b0;
      rdy_cyc = cyc;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_return got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      #1;
      checks += 6;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", cmd_ready); end
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", timeout_err); end
      if (pio_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs got %b want 0", pio_chipselect); end
      if (pio_write_n !== 1'b1) begin errors++; $display("FAIL rst_wn got %b want 1", pio_write_n); end
      if (pio_address !== 2'd0) begin errors++; $display("FAIL rst_addr got %0d want 0", pio_address); end
      if (pio_writedata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", pio_writedata); end
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write_basic();
      exp_q.delete();
      void'(model_cmd(1'b1, 8'h41, 1'b0, 1'b1, 0));
      issue(1'b1, 8'h41, 1'b0, 1'b1, 0, 1'b0);
      checks++;
      if (wr_log.size() - wb != exp_q.size()) begin
         errors++; $display("FAIL basic_nwr got %0d want %0d", wr_log.size() - wb, exp_q.size());
      end
      foreach (exp_q[i]) if (wb + i < wr_log.size()) begin
         checks++;
         if (wr_log[wb+i] !== exp_q[i]) begin
            errors++; $display("FAIL basic_wr%0d got a%0d %h want a%0d %h", i, wr_log[wb+i].addr,
                               wr_log[wb+i].data, exp_q[i].addr, exp_q[i].data);
         end
      end
      checks += 3;
      if (rdy_cyc - acc_cyc != 36) begin
         errors++; $display("FAIL basic_latency got %0d want 36", rdy_cyc - acc_cyc);
      end
      if (wr_cyc.size() >= wb + 4) begin
         if (wr_cyc[wb] - acc_cyc != 1) begin
            errors++; $display("FAIL basic_dir_cycle got %0d want 1", wr_cyc[wb] - acc_cyc);
         end
         if (wr_cyc[wb+3] - wr_cyc[wb+2] != 26) begin
            errors++; $display("FAIL basic_e_span got %0d want 26", wr_cyc[wb+3] - wr_cyc[wb+2]);
         end
      end else begin
         errors++; $display("FAIL basic_timing got %0d writes want 4", wr_cyc.size() - wb);
      end
      checks += 3;
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", timeout_err); end
      if (pio_chipselect !== 1'b0) begin errors++; $display("FAIL idle_cs got %b want 0", pio_chipselect); end
      if (pio_writedata !== 32'h0) begin errors++; $display("FAIL idle_wdata got %h want 0", pio_writedata); end
   endtask

   task automatic test_poll_busy3();
      exp_q.delete();
      void'(model_cmd(1'b0, 8'h28, 1'b1, 1'b1, 3));
      issue(1'b0, 8'h28, 1'b1, 1'b1, 3, 1'b0);
      checks++;
      if (wr_log.size() - wb != exp_q.size()) begin
         errors++; $display("FAIL poll3_nwr got %0d want %0d", wr_log.size() - wb, exp_q.size());
      end
      foreach (exp_q[i]) if (wb + i < wr_log.size()) begin
         checks++;
         if (wr_log[wb+i] !== exp_q[i]) begin
            errors++; $display("FAIL poll3_wr%0d got a%0d %h want a%0d %h", i, wr_log[wb+i].addr,
                               wr_log[wb+i].data, exp_q[i].addr, exp_q[i].data);
         end
      end
      checks += 2;
      if (rd_total - rd_base != 4) begin errors++; $display("FAIL poll3_reads got %0d want 4", rd_total - rd_base); end
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL poll3_err got %b want 0", timeout_err); end
   endtask

   task automatic test_poll_timeout();
      exp_q.delete();
      void'(model_cmd(1'b1, 8'h33, 1'b1, 1'b0, 100));
      issue(1'b1, 8'h33, 1'b1, 1'b0, 100, 1'b0);
      checks++;
      if (wr_log.size() - wb != exp_q.size()) begin
         errors++; $display("FAIL tmo_nwr got %0d want %0d", wr_log.size() - wb, exp_q.size());
      end
      foreach (exp_q[i]) if (wb + i < wr_log.size()) begin
         checks++;
         if (wr_log[wb+i] !== exp_q[i]) begin
            errors++; $display("FAIL tmo_wr%0d got a%0d %h want a%0d %h", i, wr_log[wb+i].addr,
                               wr_log[wb+i].data, exp_q[i].addr, exp_q[i].data);
         end
      end
      checks += 2;
      if (rd_total - rd_base != PollLimit) begin
         errors++; $display("FAIL tmo_reads got %0d want %0d", rd_total - rd_base, PollLimit);
      end
      if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b want 1", timeout_err); end
   endtask

   task automatic test_err_clr();
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      checks++;
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL clr_err got %b want 0", timeout_err); end
      // err_clr held through the command, so it coincides with the timeout set
      issue(1'b0, 8'h01, 1'b1, 1'b0, 100, 1'b1);
      checks++;
      if (timeout_err !== 1'b1) begin errors++; $display("FAIL clr_vs_set got %b want 1", timeout_err); end
      @(posedge clk); #1;
      checks++;
      if (timeout_err !== 1'b1) begin errors++; $display("FAIL clr_sticky got %b want 1", timeout_err); end
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
   endtask

   task automatic test_reset_mid();
      int n = 0;
      int w0;
      w0 = wr_log.size();
      cmd_rs = 1'b1; cmd_data = 8'h55; poll_en = 1'b0; bl_on = 1'b1; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      while (wr_log.size() < w0 + 3 && n < 100) begin @(posedge clk); #1; n++; end
      repeat (4) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      checks += 4;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", cmd_ready); end
      if (pio_chipselect !== 1'b0) begin errors++; $display("FAIL midrst_cs got %b want 0", pio_chipselect); end
      if (pio_write_n !== 1'b1) begin errors++; $display("FAIL midrst_wn got %b want 1", pio_write_n); end
      if (pio_writedata !== 32'h0) begin errors++; $display("FAIL midrst_wdata got %h want 0", pio_writedata); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      void'(model_cmd(1'b0, 8'h0F, 1'b0, 1'b0, 0));
      issue(1'b0, 8'h0F, 1'b0, 1'b0, 0, 1'b0);
      checks++;
      if (wr_log.size() - wb != exp_q.size()) begin
         errors++; $display("FAIL midrst_nwr got %0d want %0d", wr_log.size() - wb, exp_q.size());
      end
      foreach (exp_q[i]) if (wb + i < wr_log.size()) begin
         checks++;
         if (wr_log[wb+i] !== exp_q[i]) begin
            errors++; $display("FAIL midrst_wr%0d got %h want %h", i, wr_log[wb+i].data, exp_q[i].data);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] cmds [3] = '{8'h38, 8'h0C, 8'h01};
      int k = 0;
      int n = 0;
      wb = wr_log.size();
      ab = acc_q.size();
      rd_base = rd_total;
      busy_target = 0;
      exp_q.delete();
      for (int i = 0; i < 3; i++) void'(model_cmd(1'b0, cmds[i], 1'b0, 1'b0, 0));
      poll_en = 1'b0; cmd_rs = 1'b0; bl_on = 1'b0; cmd_data = cmds[0]; cmd_valid = 1'b1;
      while (k < 3 && n < 300) begin
         @(posedge clk); #1; n++;
         if (acc_q.size() - ab > k) begin
            k++;
            if (k < 3) cmd_data = cmds[k];
            else cmd_valid = 1'b0;
         end
      end
      cmd_valid = 1'b0;
      n = 0;
      while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
      checks++;
      if (acc_q.size() - ab != 3) begin
         errors++; $display("FAIL b2b_accepts got %0d want 3", acc_q.size() - ab);
      end else begin
         checks += 2;
         if (acc_q[ab+1] - acc_q[ab] != 36) begin
            errors++; $display("FAIL b2b_gap1 got %0d want 36", acc_q[ab+1] - acc_q[ab]);
         end
         if (acc_q[ab+2] - acc_q[ab+1] != 36) begin
            errors++; $display("FAIL b2b_gap2 got %0d want 36", acc_q[ab+2] - acc_q[ab+1]);
         end
      end
      checks++;
      if (wr_log.size() - wb != exp_q.size()) begin
         errors++; $display("FAIL b2b_nwr got %0d want %0d", wr_log.size() - wb, exp_q.size());
      end
      foreach (exp_q[i]) if (wb + i < wr_log.size()) begin
         checks++;
         if (wr_log[wb+i] !== exp_q[i]) begin
            errors++; $display("FAIL b2b_wr%0d got a%0d %h want a%0d %h", i, wr_log[wb+i].addr,
                               wr_log[wb+i].data, exp_q[i].addr, exp_q[i].data);
         end
      end
   endtask

   task automatic test_random();
      logic rs, poll, bl, to;
      logic [7:0] d;
      int busy;
      for (int t = 0; t < 10; t++) begin
         rs = 1'($urandom); poll = 1'($urandom); bl = 1'($urandom); d = 8'($urandom);
         busy = $urandom_range(0, 5);
         exp_q.delete();
         to = model_cmd(rs, d, poll, bl, busy);
         issue(rs, d, poll, bl, busy, 1'b0);
         checks++;
         if (wr_log.size() - wb != exp_q.size()) begin
            errors++; $display("FAIL rnd%0d_nwr got %0d want %0d", t, wr_log.size() - wb, exp_q.size());
         end
         foreach (exp_q[i]) if (wb + i < wr_log.size()) begin
            checks++;
            if (wr_log[wb+i] !== exp_q[i]) begin
               errors++; $display("FAIL rnd%0d_wr%0d got a%0d %h want a%0d %h", t, i, wr_log[wb+i].addr,
                                  wr_log[wb+i].data, exp_q[i].addr, exp_q[i].data);
            end
         end
         checks++;
         if (timeout_err !== to) begin
            errors++; $display("FAIL rnd%0d_err got %b want %b", t, timeout_err, to);
         end
         if (!poll) begin
            checks++;
            if (rdy_cyc - acc_cyc != 36) begin
               errors++; $display("FAIL rnd%0d_latency got %0d want 36", t, rdy_cyc - acc_cyc);
            end
         end
         if (to) begin
            err_clr = 1'b1;
            @(posedge clk); #1;
            err_clr = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_poll_busy3();
      test_poll_timeout();
      test_err_clr();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
